// File: rtl/seq_shift_add_mult_if.sv
// Request/result bundle for the iterative shift-add multiplier.
// The master issues operands with start; the slave (multiplier) returns busy/done/product_out.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_in;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product_out;

  modport master (
    output start, signed_in, a_in, b_in,
    input  busy, done, product_out
  );

  modport slave (
    input  start, signed_in, a_in, b_in,
    output busy, done, product_out
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock on operand magnitudes,
// sign applied once at the end. Optional early exit when remaining multiplier bits are zero.
module seq_shift_add_mult #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_shift_add_mult_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             done_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_iter;

  // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag = (bus.signed_in && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign b_mag = (bus.signed_in && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;

  assign last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                     (EARLY_TERM && ((mplier_q >> 1) == '0));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves no stale product behind.
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= bus.signed_in & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
          end
        end
        S_CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_FIN: begin
          product_q <= neg_q ? -acc_q : acc_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIN);
  assign bus.done        = done_q;
  assign bus.product_out = product_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: 32-bit units with and without early termination,
// plus an 8-bit unit swept against a behavioural multiply.
module tb_seq_shift_add_mult;
  logic clk;
  logic reset_n;

  int checks;
  int errors;

  // shared 32-bit operands; separate start per 32-bit unit
  logic        st0, st1, sg32;
  logic [31:0] a32, b32;
  logic        st8, sg8;
  logic [7:0]  a8, b8;

  seq_shift_add_mult_if #(.WIDTH(32)) if0 ();
  seq_shift_add_mult_if #(.WIDTH(32)) if1 ();
  seq_shift_add_mult_if #(.WIDTH(8))  if8 ();

  assign if0.start = st0;  assign if0.signed_in = sg32; assign if0.a_in = a32; assign if0.b_in = b32;
  assign if1.start = st1;  assign if1.signed_in = sg32; assign if1.a_in = a32; assign if1.b_in = b32;
  assign if8.start = st8;  assign if8.signed_in = sg8;  assign if8.a_in = a8;  assign if8.b_in = b8;

  seq_shift_add_mult #(.WIDTH(32), .EARLY_TERM(1'b0)) dut_full (.clk(clk), .reset_n(reset_n), .bus(if0));
  seq_shift_add_mult #(.WIDTH(32), .EARLY_TERM(1'b1)) dut_early (.clk(clk), .reset_n(reset_n), .bus(if1));
  seq_shift_add_mult #(.WIDTH(8),  .EARLY_TERM(1'b1)) dut_w8 (.clk(clk), .reset_n(reset_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts edges after the current point until the selected 32-bit unit pulses done; -1 on timeout.
  task automatic wait_done32(input bit sel, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if ((sel ? if1.done : if0.done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Issue one op on a 32-bit unit; called #1 after an edge with the unit idle.
  task automatic op32(input bit sel, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp_p, input int exp_lat, input string name);
    int lat;
    logic [63:0] p;
    sg32 = sgn; a32 = a; b32 = b;
    if (sel) st1 = 1'b1; else st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5679; sg32 = ~sgn;
    wait_done32(sel, 40, lat);
    p = sel ? if1.product_out : if0.product_out;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (p !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h, expected %h", name, p, exp_p);
    end
    @(posedge clk); #1;
    checks++;
    if ((sel ? if1.done : if0.done) !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done still %b one cycle later, expected 0", name, (sel ? if1.done : if0.done));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    st0 = 0; st1 = 0; st8 = 0; sg32 = 0; sg8 = 0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if0.busy, if1.busy, if8.busy} !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got %b, expected 000", {if0.busy, if1.busy, if8.busy});
    end
    checks++;
    if ({if0.done, if1.done, if8.done} !== 3'b000) begin
      errors++; $display("FAIL reset_done: got %b, expected 000", {if0.done, if1.done, if8.done});
    end
    checks++;
    if ((if0.product_out | if1.product_out | {48'h0, if8.product_out}) !== 64'h0) begin
      errors++; $display("FAIL reset_product: got %h/%h/%h, expected 0", if0.product_out, if1.product_out, if8.product_out);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({if0.busy, if1.busy, if8.busy} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: busy %b, expected 000", {if0.busy, if1.busy, if8.busy});
    end
  endtask

  task automatic test_unsigned_full();
    op32(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "unsigned_max");
    op32(0, 0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 33, "unsigned_2p32");
  endtask

  task automatic test_signed();
    op32(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 33, "s_m1_m1_full");
    op32(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, "s_min_min_full");
    op32(0, 1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 33, "s_min_1_full");
    op32(0, 1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, "s_7_m3_full");
    op32(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2,  "s_m1_m1_early");
    op32(1, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, "s_min_min_early");
    op32(1, 1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 2,  "s_min_1_early");
    op32(1, 1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3,  "s_7_m3_early");
  endtask

  task automatic test_early_term();
    op32(1, 0, 32'd5, 32'd3, 64'd15, 3, "early_5x3");
    op32(1, 0, 32'd5, 32'd0, 64'd0,  2, "early_b0");
    op32(1, 0, 32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 33, "early_b_msb");
  endtask

  task automatic test_ignore_start();
    int lat;
    lat = -1;
    sg32 = 0; a32 = 32'd3; b32 = 32'd5; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1) begin
        lat = k;
        break;
      end
      // k==5 is mid-CALC, k==32 is the FIN cycle
      if (k == 5 || k == 32) begin
        st0 = 1'b1; sg32 = 1'b1; a32 = 32'd9; b32 = 32'hFFFF_FFF7;
      end else begin
        st0 = 1'b0;
      end
    end
    st0 = 1'b0;
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL ignore_start latency: got %0d, expected 33", lat);
    end
    checks++;
    if (if0.product_out !== 64'd15) begin
      errors++; $display("FAIL ignore_start product: got %h, expected %h", if0.product_out, 64'd15);
    end
    @(posedge clk); #1;
    checks++;
    if ({if0.busy, if0.done} !== 2'b00) begin
      errors++; $display("FAIL ignore_start no_restart: busy/done %b, expected 00", {if0.busy, if0.done});
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    sg32 = 0; a32 = 32'd2; b32 = 32'd3; st0 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd4; b32 = 32'd5;   // held start samples these in the done cycle
    wait_done32(0, 40, lat1);
    checks++;
    if (lat1 !== 33) begin
      errors++; $display("FAIL b2b first_latency: got %0d, expected 33", lat1);
    end
    checks++;
    if (if0.product_out !== 64'd6) begin
      errors++; $display("FAIL b2b first_product: got %h, expected %h", if0.product_out, 64'd6);
    end
    @(posedge clk); #1;
    st0 = 1'b0;
    checks++;
    if (if0.busy !== 1'b1) begin
      errors++; $display("FAIL b2b accepted_in_done_cycle: busy %b, expected 1", if0.busy);
    end
    wait_done32(0, 40, lat2);
    if (lat2 >= 0) lat2 = lat2 + 1;
    checks++;
    if (lat2 !== 34) begin
      errors++; $display("FAIL b2b period: got %0d cycles, expected 34", lat2);
    end
    checks++;
    if (if0.product_out !== 64'd20) begin
      errors++; $display("FAIL b2b second_product: got %h, expected %h", if0.product_out, 64'd20);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    sg32 = 0; a32 = 32'd100; b32 = 32'd100; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if0.busy, if0.done} !== 2'b00) begin
      errors++; $display("FAIL reset_mid busy_done: got %b, expected 00", {if0.busy, if0.done});
    end
    checks++;
    if (if0.product_out !== 64'h0) begin
      errors++; $display("FAIL reset_mid product: got %h, expected 0", if0.product_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1 || if0.busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid no_done: %0d cycles busy/done after abort, expected 0", seen);
    end
    op32(0, 1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, "after_reset_op");
  endtask

  task automatic test_sweep8();
    logic [7:0]  va [4] = '{8'h80, 8'hFF, 8'hFF, 8'h00};
    logic [7:0]  vb [4] = '{8'h80, 8'h01, 8'hFF, 8'h7F};
    bit          vs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 24; i++) begin
      logic [7:0]         a, b, mag;
      bit                 s;
      logic signed [15:0] sp;
      logic [15:0]        exp_p;
      int                 n, lat;
      if (i < 4) begin
        a = va[i]; b = vb[i]; s = vs[i];
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); s = 1'($urandom_range(0, 1));
      end
      sp    = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
      exp_p = s ? sp : ({8'h00, a} * {8'h00, b});
      mag   = (s && b[7]) ? 8'(-b) : b;
      n = 1;
      for (int j = 0; j < 8; j++) if (mag[j]) n = j + 1;
      sg8 = s; a8 = a; b8 = b; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0; a8 = ~a; b8 = ~b;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (if8.done === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat !== n + 1) begin
        errors++; $display("FAIL sweep8[%0d] latency: got %0d, expected %0d (a=%h b=%h s=%b)", i, lat, n + 1, a, b, s);
      end
      checks++;
      if (if8.product_out !== exp_p) begin
        errors++; $display("FAIL sweep8[%0d] product: got %h, expected %h (a=%h b=%h s=%b)", i, if8.product_out, exp_p, a, b, s);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned_full();
    test_signed();
    test_early_term();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
